// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out reads win every de cycle; CPU accesses use blanking.
// Define VRAM_ARB_CPU_READ_EN to build the CPU read path; otherwise every CPU access is a write.
module vram_arbiter #(
   parameter int unsigned     P_AW        = 16,
   parameter int unsigned     P_DW        = 16,
   parameter logic [P_AW-1:0] P_BASE      = 16'd0,
   parameter int unsigned     P_FRAME_PIX = 62720
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vs_in,
   input  logic            hs_in,
   input  logic            de_in,
   output logic            vs_out,
   output logic            hs_out,
   output logic            de_out,
   output logic [P_DW-1:0] pixel_out,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [P_AW-1:0] cpu_addr,
   input  logic [P_DW-1:0] cpu_wdata,
   output logic            cpu_ack,
   output logic [P_DW-1:0] cpu_rdata,
   output logic            cpu_rvalid,
   output logic            mem_en,
   output logic            mem_we,
   output logic [P_AW-1:0] mem_addr,
   output logic [P_DW-1:0] mem_wdata,
   input  logic [P_DW-1:0] mem_rdata
);

   localparam logic [P_AW-1:0] LastAddr = P_BASE + P_AW'(P_FRAME_PIX - 1);

`ifdef VRAM_ARB_CPU_READ_EN
   typedef enum logic [1:0] {StIdle, StAck, StRd1, StRd2} state_e;
`else
   typedef enum logic {StIdle, StAck} state_e;
`endif

   state_e          state_q, state_d;
   logic [P_AW-1:0] disp_addr_q, disp_addr_d;
   logic [2:0]      vs_sr_q, hs_sr_q, de_sr_q;
   logic            armed_q, armed_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [P_AW-1:0] mem_addr_q, mem_addr_d;
   logic [P_DW-1:0] mem_wdata_q, mem_wdata_d;
   logic            cpu_ack_q, cpu_ack_d;
   logic [P_DW-1:0] pixel_q, pixel_d;
   logic            cpu_we_eff;
   logic            vs_rise;

`ifdef VRAM_ARB_CPU_READ_EN
   logic [P_DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic            cpu_rvalid_q, cpu_rvalid_d;

   assign cpu_we_eff = cpu_we;
`else
   logic unused_cpu_we;

   assign unused_cpu_we = cpu_we;
   assign cpu_we_eff    = 1'b1;
`endif

   assign vs_rise = vs_in & ~vs_sr_q[0];

   always_comb begin
      state_d     = state_q;
      disp_addr_d = disp_addr_q;
      // A request only re-arms after cpu_req has been seen low, so a held request is issued once.
      armed_d     = armed_q | ~cpu_req;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      pixel_d     = de_sr_q[1] ? mem_rdata : '0;
`ifdef VRAM_ARB_CPU_READ_EN
      cpu_rdata_d  = cpu_rdata_q;
      cpu_rvalid_d = 1'b0;
`endif

      if (vs_rise) begin
         disp_addr_d = P_BASE;
      end else if (de_in) begin
         disp_addr_d = (disp_addr_q == LastAddr) ? P_BASE : disp_addr_q + P_AW'(1);
      end

      if (de_in) begin
         mem_en_d   = 1'b1;
         mem_addr_d = disp_addr_q;
      end

      case (state_q)
         StIdle: begin
            if (cpu_req && armed_q && !de_in) begin
               mem_en_d    = 1'b1;
               mem_we_d    = cpu_we_eff;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               cpu_ack_d   = 1'b1;
               armed_d     = 1'b0;
               state_d     = StAck;
            end
         end
`ifdef VRAM_ARB_CPU_READ_EN
         // mem_we_q still holds the direction of the access issued in the previous cycle.
         StAck: state_d = mem_we_q ? StIdle : StRd1;
         StRd1: begin
            cpu_rdata_d  = mem_rdata;
            cpu_rvalid_d = 1'b1;
            state_d      = StRd2;
         end
         StRd2: state_d = StIdle;
`else
         StAck: state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         disp_addr_q <= P_BASE;
         vs_sr_q     <= '0;
         hs_sr_q     <= '0;
         de_sr_q     <= '0;
         armed_q     <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         pixel_q     <= '0;
      end else begin
         state_q     <= state_d;
         disp_addr_q <= disp_addr_d;
         vs_sr_q     <= {vs_sr_q[1:0], vs_in};
         hs_sr_q     <= {hs_sr_q[1:0], hs_in};
         de_sr_q     <= {de_sr_q[1:0], de_in};
         armed_q     <= armed_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         pixel_q     <= pixel_d;
      end
   end

`ifdef VRAM_ARB_CPU_READ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
      end else begin
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_rvalid = cpu_rvalid_q;
`else
   assign cpu_rdata  = '0;
   assign cpu_rvalid = 1'b0;
`endif

   assign vs_out    = vs_sr_q[2];
   assign hs_out    = hs_sr_q[2];
   assign de_out    = de_sr_q[2];
   assign pixel_out = pixel_q;
   assign cpu_ack   = cpu_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
